aclk_controller: RTL and testbench

ACLK_CONTROLLER -- requirements
Module: aclk_controller

---
 rtl/aclk_pkg.sv | 17 +
 rtl/aclk_keyreg.sv | 20 ++
 rtl/aclk_controller.sv | 67 ++++++
 tb/tb_aclk_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared states, constants and time-validity helper for the alarm clock controller
package aclk_pkg;
  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;
  localparam logic [3:0] NOKEY        = 4'd10;
  localparam logic [3:0] TIMEOUT_SECS = 4'd10;
  function automatic logic legal_time(input logic [3:0] ms_hr, input logic [3:0] ls_hr, input logic [3:0] ms_min);
    return (ms_hr < 4'd2 || (ms_hr == 4'd2 && ls_hr <= 4'd3)) && ms_min <= 4'd5;
  endfunction
endpackage

// File: rtl/aclk_keyreg.sv
// aclk_keyreg: four-digit key buffer that shifts new digits in from the right
module aclk_keyreg
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift,
  input  logic [3:0] key,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min
);
  // clear wins over shift so a fresh entry always starts from 0000
  always_ff @(posedge clk or negedge reset)
    if (!reset) {ms_hr, ls_hr, ms_min, ls_min} <= '0;
    else if (clear) {ms_hr, ls_hr, ms_min, ls_min} <= '0;
    else if (shift) {ms_hr, ls_hr, ms_min, ls_min} <= {ls_hr, ms_min, ls_min, key};
endmodule

// File: rtl/aclk_controller.sv
// aclk_controller: keypad entry FSM with timeout and current-time validity check
module aclk_controller
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error
);
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       w_valid, w_timeout, w_clear, w_shift, w_legal;
  assign w_valid   = key <= 4'd9;
  assign w_timeout = r_cnt == TIMEOUT_SECS;
  assign w_clear   = r_state == SHOW_TIME && w_next == KEY_STORED;
  assign w_shift   = r_state == KEY_STORED;
  assign w_legal   = legal_time(key_ms_hr, key_ls_hr, key_ms_min);
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= SHOW_TIME;
    else r_state <= w_next;
  // next-state decode; keys only count after NOKEY was seen in KEY_WAITED
  always_comb begin
    w_next = r_state;
    case (r_state)
      SHOW_TIME:        w_next = alarm_button ? SHOW_ALARM : w_valid ? KEY_STORED : SHOW_TIME;
      KEY_STORED:       w_next = KEY_WAITED;
      KEY_WAITED:       w_next = !w_valid ? KEY_ENTRY : w_timeout ? SHOW_TIME : KEY_WAITED;
      KEY_ENTRY:        w_next = alarm_button ? SET_ALARM_TIME : time_button ? SET_CURRENT_TIME :
                                 w_valid ? KEY_STORED : w_timeout ? SHOW_TIME : KEY_ENTRY;
      SHOW_ALARM:       w_next = alarm_button ? SHOW_ALARM : SHOW_TIME;
      default:          w_next = SHOW_TIME;
    endcase
  end
  // seconds since the last accepted key; a new key restarts the count
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (w_next == KEY_STORED) r_cnt <= '0;
    else if ((r_state == KEY_WAITED || r_state == KEY_ENTRY) && one_second) r_cnt <= r_cnt + 4'd1;
  aclk_keyreg u_keyreg (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .shift  (w_shift),
    .key    (key),
    .ms_hr  (key_ms_hr),
    .ls_hr  (key_ls_hr),
    .ms_min (key_ms_min),
    .ls_min (key_ls_min)
  );
  assign show_new_time = r_state inside {KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM_TIME, SET_CURRENT_TIME};
  assign show_a        = r_state == SHOW_ALARM;
  assign load_new_a    = r_state == SET_ALARM_TIME;
  assign load_new_c    = r_state == SET_CURRENT_TIME && w_legal;
  assign entry_error   = r_state == SET_CURRENT_TIME && !w_legal;
endmodule

// File: tb/tb_aclk_controller.sv
// tb_aclk_controller: directed checks of key entry, loads, timeout and reset
module tb_aclk_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd10;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       load_new_c, load_new_a, show_new_time, show_a, entry_error;
  logic [15:0] w_buf;
  int total = 0;
  int bad = 0;
  int cnt;
  logic [15:0] vec_digits [3];
  logic        vec_load   [3];
  assign w_buf = {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
  always #5 clk = ~clk;
  aclk_controller dut (
    .clk           (clk),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key_ms_hr     (key_ms_hr),
    .key_ls_hr     (key_ls_hr),
    .key_ms_min    (key_ms_min),
    .key_ls_min    (key_ls_min),
    .load_new_c    (load_new_c),
    .load_new_a    (load_new_a),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .entry_error   (entry_error)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(input logic [3:0] k);
    key = k;
    tick(2);
    key = 4'd10;
    tick(2);
  endtask
  task automatic enter(input logic [15:0] d);
    press(d[15:12]);
    press(d[11:8]);
    press(d[7:0] >> 4);
    press(d[3:0]);
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      one_second = 1'b1;
      tick(1);
      one_second = 1'b0;
      tick(1);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_digits[0] = 16'h2359; vec_load[0] = 1'b1;
    vec_digits[1] = 16'h2400; vec_load[1] = 1'b0;
    vec_digits[2] = 16'h1960; vec_load[2] = 1'b0;
    tick(2);
    check("rst_outs", {11'd0, load_new_c, load_new_a, show_new_time, show_a, entry_error}, 16'h0);
    check("rst_buf", w_buf, 16'h0000);
    reset = 1'b1;
    tick(1);
    key = 4'd12;
    tick(2);
    check("ignored_key", {15'd0, show_new_time}, 16'h0);
    key = 4'd10;
    tick(1);
    enter(16'h2358);
    check("buf_2358", w_buf, 16'h2358);
    check("entry_shown", {15'd0, show_new_time}, 16'h1);
    time_button = 1'b1;
    tick(1);
    check("load_c_2358", {15'd0, load_new_c}, 16'h1);
    check("err_2358", {15'd0, entry_error}, 16'h0);
    time_button = 1'b0;
    cnt = 0;
    repeat (4) begin
      tick(1);
      cnt += int'(load_new_c);
    end
    check("load_c_once", 16'(cnt), 16'd0);
    check("back_show_time", {14'd0, show_new_time, show_a}, 16'h0);
    check("buf_kept", w_buf, 16'h2358);
    foreach (vec_digits[i]) begin
      enter(vec_digits[i]);
      time_button = 1'b1;
      tick(1);
      check($sformatf("legal_load_%h", vec_digits[i]), {15'd0, load_new_c}, {15'd0, vec_load[i]});
      check($sformatf("legal_err_%h", vec_digits[i]), {15'd0, entry_error}, {15'd0, !vec_load[i]});
      time_button = 1'b0;
      tick(2);
    end
    enter(16'h2500);
    time_button = 1'b1;
    tick(1);
    check("err_2500", {14'd0, entry_error, load_new_c}, 16'b10);
    time_button = 1'b0;
    tick(1);
    check("err_pulse_end", {15'd0, entry_error}, 16'h0);
    enter(16'h0730);
    alarm_button = 1'b1;
    tick(1);
    check("load_a", {14'd0, load_new_a, load_new_c}, 16'b10);
    check("buf_0730", w_buf, 16'h0730);
    alarm_button = 1'b0;
    tick(1);
    check("load_a_end", {15'd0, load_new_a}, 16'h0);
    alarm_button = 1'b1;
    tick(3);
    check("show_alarm", {14'd0, show_a, show_new_time}, 16'b10);
    alarm_button = 1'b0;
    tick(1);
    check("alarm_release", {15'd0, show_a}, 16'h0);
    press(4'd4);
    pulses(9);
    key = 4'd5;
    one_second = 1'b1;
    tick(1);
    one_second = 1'b0;
    tick(1);
    key = 4'd10;
    tick(2);
    check("buf_45", w_buf, 16'h0045);
    pulses(9);
    check("no_timeout_9", {15'd0, show_new_time}, 16'h1);
    pulses(1);
    check("timeout_10", {15'd0, show_new_time}, 16'h0);
    key = 4'd6;
    tick(5);
    key = 4'd10;
    tick(2);
    check("held_key", w_buf, 16'h0006);
    press(4'd1);
    press(4'd2);
    check("buf_0612", w_buf, 16'h0612);
    #3 reset = 1'b0;
    #1;
    check("rst_mid_state", {14'd0, show_new_time, show_a}, 16'h0);
    check("rst_mid_buf", w_buf, 16'h0000);
    time_button = 1'b1;
    cnt = 0;
    repeat (3) begin
      tick(1);
      cnt += int'(load_new_c) + int'(load_new_a) + int'(entry_error);
    end
    check("rst_no_load", 16'(cnt), 16'd0);
    time_button = 1'b0;
    #2 reset = 1'b1;
    tick(1);
    check("post_rst_idle", {14'd0, show_new_time, show_a}, 16'h0);
    press(4'd9);
    check("post_rst_key", w_buf, 16'h0009);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
